// File: rtl/run_ctrl_if.sv
// Control/status bundle between the run controller and whoever drives it
// (debug logic, bench, core). The master drives requests and core status;
// the slave is the run controller itself.
interface run_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int STEP_W = 16,
  parameter int CNT_W  = 32
);
  logic              run_req;
  logic              halt_req;
  logic              step_req;
  logic [STEP_W-1:0] step_n;
  logic              halt_instr;
  logic              bp_en;
  logic [ADDR_W-1:0] bp_addr;
  logic [ADDR_W-1:0] pc;
  logic              cpu_en;
  logic [1:0]        state;
  logic              bp_hit;
  logic [CNT_W-1:0]  cycle_count;

  modport master (
    output run_req, halt_req, step_req, step_n, halt_instr, bp_en, bp_addr, pc,
    input  cpu_en, state, bp_hit, cycle_count
  );

  modport slave (
    input  run_req, halt_req, step_req, step_n, halt_instr, bp_en, bp_addr, pc,
    output cpu_en, state, bp_hit, cycle_count
  );
endinterface

// File: rtl/run_ctrl.sv
// Run/halt/single-step controller producing the core clock enable.
// Gates execution by free run, N-cycle stepping and a PC breakpoint, and
// counts enabled cycles. All outputs decode from registers only.
module run_ctrl #(
  parameter int ADDR_W = 16,
  parameter int STEP_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic      clk,
  input  logic      reset,
  run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_HALTED = 2'b00,
    S_RUN    = 2'b01,
    S_STEP   = 2'b10,
    S_BREAK  = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_left_q, step_left_d;
  logic              bp_skip_q, bp_skip_d;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;

  logic              cpu_en;
  logic              bp_match;
  logic              step_ok;

  assign cpu_en   = (state_q == S_RUN) || (state_q == S_STEP);
  // Skip flag lets the core execute the breakpoint PC once after resuming.
  assign bp_match = bus.bp_en && (bus.pc == bus.bp_addr) && !bp_skip_q;
  assign step_ok  = bus.step_req && (bus.step_n != '0);

  // Next-state, step countdown, breakpoint skip and cycle counter.
  always_comb begin
    state_d       = state_q;
    step_left_d   = step_left_q;
    bp_skip_d     = bp_skip_q;
    cycle_count_d = cycle_count_q + CNT_W'(cpu_en);

    case (state_q)
      S_HALTED: begin
        if (bus.halt_req) begin
          state_d = S_HALTED;
        end else if (bus.run_req) begin
          state_d = S_RUN;
        end else if (step_ok) begin
          state_d     = S_STEP;
          step_left_d = bus.step_n;
        end
      end

      S_RUN, S_STEP: begin
        // The skip only covers the first enabled cycle after BREAK.
        bp_skip_d = 1'b0;
        if (state_q == S_STEP) begin
          step_left_d = step_left_q - STEP_W'(1);
        end
        if (bus.halt_req || bus.halt_instr) begin
          state_d     = S_HALTED;
          step_left_d = '0;
        end else if (bp_match) begin
          state_d     = S_BREAK;
          step_left_d = '0;
        end else if ((state_q == S_STEP) && (step_left_q == STEP_W'(1))) begin
          state_d     = S_HALTED;
          step_left_d = '0;
        end
      end

      S_BREAK: begin
        if (bus.halt_req) begin
          state_d = S_HALTED;
        end else if (bus.run_req) begin
          state_d   = S_RUN;
          bp_skip_d = 1'b1;
        end else if (step_ok) begin
          state_d     = S_STEP;
          step_left_d = bus.step_n;
          bp_skip_d   = 1'b1;
        end
      end

      default: state_d = S_HALTED;
    endcase
  end

  // State and counters, synchronously reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_HALTED;
      step_left_q   <= '0;
      bp_skip_q     <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      step_left_q   <= step_left_d;
      bp_skip_q     <= bp_skip_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign bus.cpu_en      = cpu_en;
  assign bus.state       = state_q;
  assign bus.bp_hit      = (state_q == S_BREAK);
  assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: a 32-bit counter instance for the functional
// scenarios and a 4-bit counter instance for the wrap case.
module tb_run_ctrl;

  localparam logic [1:0] HLT = 2'b00;
  localparam logic [1:0] RUN = 2'b01;
  localparam logic [1:0] STP = 2'b10;
  localparam logic [1:0] BRK = 2'b11;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  run_ctrl_if #(.ADDR_W(16), .STEP_W(16), .CNT_W(32)) b0 ();
  run_ctrl_if #(.ADDR_W(16), .STEP_W(16), .CNT_W(4))  b1 ();

  run_ctrl #(.ADDR_W(16), .STEP_W(16), .CNT_W(32)) dut0 (
    .clk   (clk),
    .reset (rst0),
    .bus   (b0.slave)
  );

  run_ctrl #(.ADDR_W(16), .STEP_W(16), .CNT_W(4)) dut1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (b1.slave)
  );

  typedef struct {
    int          sel;
    string       tag;
    logic [1:0]  st;
    logic        en;
    logic        hit;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Push the expectation, advance one edge, then pop and compare.
  task automatic step(input int sel, input string tag, input logic [1:0] st,
                      input logic en, input logic hit, input logic [31:0] cnt);
    exp_t e;
    e.sel = sel; e.tag = tag; e.st = st; e.en = en; e.hit = hit; e.cnt = cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.sel == 0) begin
      cmp({e.tag, "_state"}, 32'(b0.state), 32'(e.st));
      cmp({e.tag, "_en"},    32'(b0.cpu_en), 32'(e.en));
      cmp({e.tag, "_hit"},   32'(b0.bp_hit), 32'(e.hit));
      cmp({e.tag, "_cnt"},   b0.cycle_count, e.cnt);
    end else begin
      cmp({e.tag, "_state"}, 32'(b1.state), 32'(e.st));
      cmp({e.tag, "_en"},    32'(b1.cpu_en), 32'(e.en));
      cmp({e.tag, "_hit"},   32'(b1.bp_hit), 32'(e.hit));
      cmp({e.tag, "_cnt"},   32'(b1.cycle_count), e.cnt);
    end
  endtask

  initial begin
    b0.run_req = 0; b0.halt_req = 0; b0.step_req = 0; b0.step_n = 0;
    b0.halt_instr = 0; b0.bp_en = 0; b0.bp_addr = 0; b0.pc = 0;
    b1.run_req = 0; b1.halt_req = 0; b1.step_req = 0; b1.step_n = 0;
    b1.halt_instr = 0; b1.bp_en = 0; b1.bp_addr = 0; b1.pc = 0;
    rst0 = 1; rst1 = 1;

    // Reset state
    step(0, "reset0", HLT, 0, 0, 0);
    step(1, "reset1", HLT, 0, 0, 0);
    cmp("reset_step_left", 32'(dut0.step_left_q), 0);
    cmp("reset_bp_skip", 32'(dut0.bp_skip_q), 0);
    rst0 = 0; rst1 = 0;

    // Free run for 10 counted cycles, then halt
    b0.run_req = 1;
    step(0, "run_start", RUN, 1, 0, 0);
    b0.run_req = 0;
    for (int i = 1; i <= 9; i++) step(0, $sformatf("run%0d", i), RUN, 1, 0, i);
    b0.halt_req = 1;
    step(0, "run_halt", HLT, 0, 0, 10);
    b0.halt_req = 0;
    step(0, "run_idle", HLT, 0, 0, 10);

    // Step 3, then a zero-length step request is ignored
    b0.step_req = 1; b0.step_n = 3;
    step(0, "step3_a", STP, 1, 0, 10);
    b0.step_req = 0; b0.step_n = 0;
    step(0, "step3_b", STP, 1, 0, 11);
    step(0, "step3_c", STP, 1, 0, 12);
    step(0, "step3_end", HLT, 0, 0, 13);
    b0.step_req = 1; b0.step_n = 0;
    step(0, "step0_a", HLT, 0, 0, 13);
    b0.step_req = 0;
    step(0, "step0_b", HLT, 0, 0, 13);

    // HLT instruction on 3rd enabled cycle of an 8-step
    b0.step_req = 1; b0.step_n = 8;
    step(0, "hlt_load", STP, 1, 0, 13);
    b0.step_req = 0; b0.step_n = 0;
    cmp("hlt_step_left_loaded", 32'(dut0.step_left_q), 8);
    step(0, "hlt_c1", STP, 1, 0, 14);
    step(0, "hlt_c2", STP, 1, 0, 15);
    b0.halt_instr = 1;
    step(0, "hlt_c3", HLT, 0, 0, 16);
    b0.halt_instr = 0;
    cmp("hlt_step_left", 32'(dut0.step_left_q), 0);

    // Simultaneous requests
    b0.run_req = 1; b0.halt_req = 1;
    step(0, "sim_run_halt", HLT, 0, 0, 16);
    b0.halt_req = 0; b0.step_req = 1; b0.step_n = 4;
    step(0, "sim_run_step", RUN, 1, 0, 16);
    b0.run_req = 0; b0.step_req = 0; b0.step_n = 0;
    b0.halt_req = 1;
    step(0, "sim_halt", HLT, 0, 0, 17);
    b0.halt_req = 0;

    // Breakpoint at pc 5, resume past it, hit again after pc wraps
    b0.bp_en = 1; b0.bp_addr = 16'h0005; b0.pc = 0; b0.run_req = 1;
    step(0, "bp_start", RUN, 1, 0, 17);
    b0.run_req = 0;
    for (int i = 0; i < 5; i++) begin
      b0.pc = 16'(i);
      step(0, $sformatf("bp_pc%0d", i), RUN, 1, 0, 18 + i);
    end
    b0.pc = 16'h0005;
    step(0, "bp_hit", BRK, 0, 1, 23);
    step(0, "bp_hold", BRK, 0, 1, 23);
    b0.run_req = 1;
    step(0, "bp_resume", RUN, 1, 0, 23);
    b0.run_req = 0;
    step(0, "bp_skip_pc5", RUN, 1, 0, 24);
    for (int i = 0; i < 7; i++) begin
      b0.pc = 16'((6 + i) % 8);
      step(0, $sformatf("bp_wrap%0d", i), RUN, 1, 0, 25 + i);
    end
    b0.pc = 16'h0005;
    step(0, "bp_rehit", BRK, 0, 1, 32);
    b0.halt_req = 1;
    step(0, "bp_halt", HLT, 0, 0, 32);
    b0.halt_req = 0; b0.bp_en = 0;

    // 4-bit counter wraps after 17 cycles; reset mid-step
    b1.run_req = 1;
    step(1, "wrap_start", RUN, 1, 0, 0);
    b1.run_req = 0;
    for (int i = 1; i <= 16; i++) step(1, $sformatf("wrap%0d", i), RUN, 1, 0, i % 16);
    b1.halt_req = 1;
    step(1, "wrap_halt", HLT, 0, 0, 1);
    b1.halt_req = 0; b1.step_req = 1; b1.step_n = 5;
    step(1, "wrap_step", STP, 1, 0, 1);
    b1.step_req = 0; b1.step_n = 0;
    step(1, "wrap_step2", STP, 1, 0, 2);
    rst1 = 1;
    step(1, "wrap_reset", HLT, 0, 0, 0);
    cmp("wrap_reset_step_left", 32'(dut1.step_left_q), 0);
    cmp("wrap_reset_bp_skip", 32'(dut1.bp_skip_q), 0);
    rst1 = 0;
    step(1, "wrap_after", HLT, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run/halt/single-step controller that consumes the free-running `clk` from the `clock` block and produces the per-cycle enable for the 16-bit processor core. It sits between the clock generator and the CPU datapath. It gates execution with three mechanisms: free run, N-cycle stepping, and a PC breakpoint. It also counts executed cycles for the bench and debug logic.

## Interface
Parameters:
- `ADDR_W`, 16: width of `pc` and `bp_addr`.
- `STEP_W`, 16: width of `step_n` and the internal step counter.
- `CNT_W`, 32: width of `cycle_count`.

Ports:
- `clk`  input  1  clock, the output of the `clock` block; all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `run_req`  input  1  level/pulse; request free run.
- `halt_req`  input  1  request stop; highest priority.
- `step_req`  input  1  request execution of `step_n` cycles.
- `step_n`  input  STEP_W  step count; sampled with `step_req`.
- `halt_instr`  input  1  core decoded HLT in the current enabled cycle.
- `bp_en`  input  1  breakpoint enable.
- `bp_addr`  input  ADDR_W  breakpoint address.
- `pc`  input  ADDR_W  core program counter for the current cycle.
- `cpu_en`  output  1  core clock enable.
- `state`  output  2  00 HALTED, 01 RUN, 10 STEP, 11 BREAK.
- `bp_hit`  output  1  high while in BREAK.
- `cycle_count`  output  CNT_W  number of cycles with `cpu_en`=1.

## Operation
- State register, 4 states; `cpu_en` = (state==RUN) | (state==STEP), decoded from the registered state with no input-to-output combinational path.
- **Stop conditions.** These apply only while `cpu_en`=1 and are evaluated in this priority order:
  1. `halt_req` moves the block to HALTED.
  2. `halt_instr` moves the block to HALTED.
  3. A breakpoint hit (`bp_en` & `pc`==`bp_addr` & !`bp_skip`) moves the block to BREAK.
- **HALTED.** Also reached via `halt_req` from any state.
  - `run_req` moves to RUN.
  - Otherwise, `step_req` with `step_n`≠0 moves to STEP and loads `step_left`=`step_n`.
  - `step_req` with `step_n`=0 is ignored.
- **RUN.** Exits only on a stop condition. `run_req` and `step_req` are ignored.
- **STEP.**
  - `step_left` decrements every cycle.
  - When `step_left`==1 and no stop condition occurs, the next state is HALTED.
  - Stop conditions override the countdown. On any exit, `step_left` is cleared to 0.
  - `step_req` and `run_req` are ignored.
- **BREAK.**
  - `bp_hit`=1.
  - `run_req` moves to RUN; `step_req` (with `step_n`≠0) moves to STEP. Either exit sets `bp_skip`=1.
  - `halt_req` moves to HALTED and clears `bp_hit`.
- **`bp_skip`.** Suppresses the breakpoint compare for exactly the first enabled cycle after leaving BREAK, so execution proceeds past the breakpoint PC. It clears after that cycle.
- **`cycle_count`.** Increments by 1 on every edge where `cpu_en`=1 and wraps from 2^CNT_W−1 to 0. It is cleared only by `reset`.
- **Simultaneous inputs.**
  - `halt_req` beats `run_req` and `step_req`.
  - In HALTED or BREAK, `run_req` beats `step_req`.

## Timing
- Reset (synchronous, sampled on the rising edge):
  - State HALTED.
  - `cpu_en`=0, `bp_hit`=0, `cycle_count`=0.
  - `step_left`=0, `bp_skip`=0.
- Reset asserted mid-RUN or mid-STEP forces these values on the next edge. The pending step count is discarded.
- Request latency is 1 cycle.
  - `run_req` sampled at edge N gives `cpu_en`=1 after edge N.
  - The first counted cycle is edge N+1.
- Step: `step_req` with `step_n`=K at edge N gives `cpu_en`=1 for exactly K cycles, at edges N+1 … N+K, then 0.
- Stop latency: a stop condition sampled at edge M gives `cpu_en`=0 after edge M. The cycle at edge M is still counted, because `cpu_en` was 1.
- `bp_hit` rises and falls in the same cycle as the corresponding state change.

## Test plan
- **Reset then run.** Stimulus: reset, then `run_req` pulse, then 10 cycles, then `halt_req`. Required response: `state` goes 00→01→00; `cycle_count`=10 (±0 per the latency rules); `cpu_en` is low after halt.
- **Step.** Stimulus: `step_req` with `step_n`=3, then `step_req` with `step_n`=0. Required response: `cpu_en` is high for exactly 3 cycles; `cycle_count`=3; the second request is ignored and `state` stays 00.
- **Breakpoint.** Stimulus: `bp_en`=1, `bp_addr`=16'h0005, `pc` increments from 0 while running. Required response: `state`=11 and `bp_hit`=1 after the cycle where `pc`=5. A subsequent `run_req` resumes with `pc`=5 not re-triggering; a later wrap to `pc`=5 triggers again.
- **HLT during STEP.** Stimulus: `step_n`=8, with `halt_instr` asserted on the 3rd enabled cycle. Required response: HALTED after 3 cycles; `step_left`=0; `cycle_count`=3.
- **Simultaneous requests.** Stimulus: `run_req` with `halt_req` asserted together in HALTED. Required response: stays in HALTED. Stimulus: `run_req` with `step_req` asserted together in HALTED. Required response: RUN.
- **Wrap and reset.** Stimulus: CNT_W=4 instance running 17 cycles, then reset asserted mid-STEP. Required response: `cycle_count`=1 after the 17 cycles; all outputs return to their reset values on the next edge.
